rename_reg_file: RTL and testbench

RENAME_REG_FILE -- requirements
Module: rename_reg_file

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_read_port.sv | 67 ++++++
 rtl/rename_reg_file.sv | 142 ++++++++++++++
 tb/tb_rename_reg_file.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and width helpers for the rename register file.
// Optional build macro used by this block: RENAME_RF_CMT_BYPASS_EN.
package rf_pkg;

    localparam int NO_TAG    = 0;
    localparam int ZERO_REG  = 0;
    localparam int ZERO_WORD = 0;

    // Width of an architectural register index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold 0..n.
    function automatic int cnt_w(input int n);
        return idx_w(n) + 1;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One operand read port: zero register, intra-bundle rename, rollback and table lookup.
// With RENAME_RF_CMT_BYPASS_EN defined, same-cycle commits are forwarded.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = 4,
    parameter int DISP_W   = 2,
    parameter int CMT_W    = 2,
    parameter int SLOT     = 0
) (
    input  logic [idx_w(NUM_REGS)-1:0]        src,
    input  logic [ROB_W-1:0]                  tag_entry,
    input  logic [DATA_W-1:0]                 val_entry,
    input  logic [DISP_W-1:0]                 disp_en,
    input  logic [DISP_W*idx_w(NUM_REGS)-1:0] disp_rd,
    input  logic [DISP_W*ROB_W-1:0]           disp_q,
    input  logic                              rollback,
`ifdef RENAME_RF_CMT_BYPASS_EN
    input  logic [CMT_W-1:0]                  cmt_en,
    input  logic [CMT_W*idx_w(NUM_REGS)-1:0]  cmt_rd,
    input  logic [CMT_W*ROB_W-1:0]            cmt_q,
    input  logic [CMT_W*DATA_W-1:0]           cmt_v,
`endif
    output logic [ROB_W-1:0]                  q,
    output logic [DATA_W-1:0]                 v
);

    localparam int IW = idx_w(NUM_REGS);

    // Priority select; later assignments override earlier ones.
    always_comb begin
        q = tag_entry;
        v = val_entry;
`ifdef RENAME_RF_CMT_BYPASS_EN
        // Youngest matching commit port is visited last and therefore wins.
        for (int p = 0; p < CMT_W; p++) begin
            if (cmt_en[p] && (cmt_rd[p*IW +: IW] == src)) begin
                v = cmt_v[p*DATA_W +: DATA_W];
                q = (cmt_q[p*ROB_W +: ROB_W] == tag_entry) ? ROB_W'(NO_TAG) : tag_entry;
            end else begin
                v = v;
            end
        end
`endif
        if (rollback) begin
            q = ROB_W'(NO_TAG);
        end else begin
            q = q;
        end
        for (int j = 0; j < DISP_W; j++) begin
            if ((j < SLOT) && disp_en[j] && (disp_rd[j*IW +: IW] == src)) begin
                q = disp_q[j*ROB_W +: ROB_W];
            end else begin
                q = q;
            end
        end
        if (src == IW'(ZERO_REG)) begin
            q = ROB_W'(NO_TAG);
            v = DATA_W'(ZERO_WORD);
        end else begin
            v = v;
        end
    end

endmodule

// File: rtl/rename_reg_file.sv
// Rename register file: per-register producer tag and committed value tables.
// Build macro RENAME_RF_CMT_BYPASS_EN forwards same-cycle commits to the read ports.
module rename_reg_file
    import rf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = 4,
    parameter int DISP_W   = 2,
    parameter int CMT_W    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DISP_W-1:0]                 disp_en,
    input  logic [DISP_W*idx_w(NUM_REGS)-1:0] disp_rs1,
    input  logic [DISP_W*idx_w(NUM_REGS)-1:0] disp_rs2,
    input  logic [DISP_W*idx_w(NUM_REGS)-1:0] disp_rd,
    input  logic [DISP_W*ROB_W-1:0]           disp_q,
    output logic [DISP_W*DATA_W-1:0]          rd_v1,
    output logic [DISP_W*DATA_W-1:0]          rd_v2,
    output logic [DISP_W*ROB_W-1:0]           rd_q1,
    output logic [DISP_W*ROB_W-1:0]           rd_q2,
    input  logic [CMT_W-1:0]                  cmt_en,
    input  logic [CMT_W*idx_w(NUM_REGS)-1:0]  cmt_rd,
    input  logic [CMT_W*ROB_W-1:0]            cmt_q,
    input  logic [CMT_W*DATA_W-1:0]           cmt_v,
    input  logic                              rollback,
    output logic [cnt_w(NUM_REGS)-1:0]        pending_cnt
);

    localparam int IW = idx_w(NUM_REGS);
    localparam int CW = cnt_w(NUM_REGS);

    logic [ROB_W-1:0]  tag_r  [NUM_REGS];
    logic [DATA_W-1:0] val_r  [NUM_REGS];
    logic [ROB_W-1:0]  tag_nx [NUM_REGS];
    logic [DATA_W-1:0] val_nx [NUM_REGS];
    logic [CW-1:0]     cnt_nx;

    // Next table state: commits first, then allocations so a same-cycle allocation wins.
    always_comb begin
        tag_nx = tag_r;
        val_nx = val_r;
        for (int p = 0; p < CMT_W; p++) begin
            if (cmt_en[p] && (cmt_rd[p*IW +: IW] != IW'(ZERO_REG))) begin
                val_nx[cmt_rd[p*IW +: IW]] = cmt_v[p*DATA_W +: DATA_W];
                if (tag_r[cmt_rd[p*IW +: IW]] == cmt_q[p*ROB_W +: ROB_W]) begin
                    tag_nx[cmt_rd[p*IW +: IW]] = ROB_W'(NO_TAG);
                end else begin
                    tag_nx[cmt_rd[p*IW +: IW]] = tag_nx[cmt_rd[p*IW +: IW]];
                end
            end else begin
                val_nx[0] = DATA_W'(ZERO_WORD);
            end
        end
        if (rollback) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_nx[r] = ROB_W'(NO_TAG);
            end
        end else begin
            for (int s = 0; s < DISP_W; s++) begin
                if (disp_en[s] && (disp_rd[s*IW +: IW] != IW'(ZERO_REG))) begin
                    tag_nx[disp_rd[s*IW +: IW]] = disp_q[s*ROB_W +: ROB_W];
                end else begin
                    tag_nx[0] = ROB_W'(NO_TAG);
                end
            end
        end
    end

    // Count of registers that will hold a pending tag after this edge.
    always_comb begin
        cnt_nx = CW'(0);
        for (int r = 0; r < NUM_REGS; r++) begin
            if (tag_nx[r] != ROB_W'(NO_TAG)) begin
                cnt_nx = cnt_nx + CW'(1);
            end else begin
                cnt_nx = cnt_nx;
            end
        end
    end

    // Table and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_r[r] <= ROB_W'(NO_TAG);
                val_r[r] <= DATA_W'(ZERO_WORD);
            end
            pending_cnt <= CW'(0);
        end else begin
            tag_r       <= tag_nx;
            val_r       <= val_nx;
            pending_cnt <= cnt_nx;
        end
    end

    for (genvar k = 0; k < DISP_W; k++) begin : g_slot
        rf_read_port #(
            .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ROB_W(ROB_W),
            .DISP_W(DISP_W), .CMT_W(CMT_W), .SLOT(k)
        ) u_rs1 (
            .src       (disp_rs1[k*IW +: IW]),
            .tag_entry (tag_r[disp_rs1[k*IW +: IW]]),
            .val_entry (val_r[disp_rs1[k*IW +: IW]]),
            .disp_en   (disp_en),
            .disp_rd   (disp_rd),
            .disp_q    (disp_q),
            .rollback  (rollback),
`ifdef RENAME_RF_CMT_BYPASS_EN
            .cmt_en    (cmt_en),
            .cmt_rd    (cmt_rd),
            .cmt_q     (cmt_q),
            .cmt_v     (cmt_v),
`endif
            .q         (rd_q1[k*ROB_W +: ROB_W]),
            .v         (rd_v1[k*DATA_W +: DATA_W])
        );

        rf_read_port #(
            .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ROB_W(ROB_W),
            .DISP_W(DISP_W), .CMT_W(CMT_W), .SLOT(k)
        ) u_rs2 (
            .src       (disp_rs2[k*IW +: IW]),
            .tag_entry (tag_r[disp_rs2[k*IW +: IW]]),
            .val_entry (val_r[disp_rs2[k*IW +: IW]]),
            .disp_en   (disp_en),
            .disp_rd   (disp_rd),
            .disp_q    (disp_q),
            .rollback  (rollback),
`ifdef RENAME_RF_CMT_BYPASS_EN
            .cmt_en    (cmt_en),
            .cmt_rd    (cmt_rd),
            .cmt_q     (cmt_q),
            .cmt_v     (cmt_v),
`endif
            .q         (rd_q2[k*ROB_W +: ROB_W]),
            .v         (rd_v2[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed, table-driven bench for rename_reg_file (default parameters).
// Honours RENAME_RF_CMT_BYPASS_EN for the same-cycle commit read expectation.
module tb_rename_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  disp_en;
    logic [9:0]  disp_rs1, disp_rs2, disp_rd;
    logic [7:0]  disp_q;
    logic [63:0] rd_v1, rd_v2;
    logic [7:0]  rd_q1, rd_q2;
    logic [1:0]  cmt_en;
    logic [9:0]  cmt_rd;
    logic [7:0]  cmt_q;
    logic [63:0] cmt_v;
    logic        rollback;
    logic [5:0]  pending_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rename_reg_file dut (
        .clk(clk), .rst(rst),
        .disp_en(disp_en), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
        .disp_rd(disp_rd), .disp_q(disp_q),
        .rd_v1(rd_v1), .rd_v2(rd_v2), .rd_q1(rd_q1), .rd_q2(rd_q2),
        .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_q(cmt_q), .cmt_v(cmt_v),
        .rollback(rollback), .pending_cnt(pending_cnt)
    );

    typedef struct {
        logic [1:0]        den;
        logic [1:0][4:0]   rs1, rs2, rd;
        logic [1:0][3:0]   dq;
        logic [1:0]        cen;
        logic [1:0][4:0]   crd;
        logic [1:0][3:0]   cq;
        logic [1:0][31:0]  cv;
        logic              rb;
        logic [1:0][3:0]   eq1, eq2;
        logic [1:0][31:0]  ev1, ev2;
        logic [5:0]        ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    task automatic idle();
        disp_en = 2'b00; disp_rs1 = 10'd0; disp_rs2 = 10'd0; disp_rd = 10'd0; disp_q = 8'd0;
        cmt_en = 2'b00; cmt_rd = 10'd0; cmt_q = 8'd0; cmt_v = 64'd0; rollback = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        disp_en = v.den; disp_rs1 = v.rs1; disp_rs2 = v.rs2; disp_rd = v.rd; disp_q = v.dq;
        cmt_en = v.cen; cmt_rd = v.crd; cmt_q = v.cq; cmt_v = v.cv; rollback = v.rb;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        idle();

        // V0 rename chain
        v = '{default: '0}; v.den = 2'b01; v.rd[0] = 5'd5; v.dq[0] = 4'd3;
        v.rs1[0] = 5'd5; v.rs1[1] = 5'd5; v.eq1[1] = 4'd3; v.ecnt = 6'd1; vecs.push_back(v);
        // V1 table read, slot1 does not rename its own operand
        v = '{default: '0}; v.rs1[0] = 5'd5; v.eq1[0] = 4'd3;
        v.den = 2'b10; v.rd[1] = 5'd7; v.dq[1] = 4'd4; v.rs2[1] = 5'd7; v.rs2[0] = 5'd7;
        v.ecnt = 6'd2; vecs.push_back(v);
        // V2 rd collision across slots, youngest wins
        v = '{default: '0}; v.den = 2'b11; v.rd[0] = 5'd9; v.dq[0] = 4'd1; v.rd[1] = 5'd9; v.dq[1] = 4'd2;
        v.rs1[1] = 5'd9; v.eq1[1] = 4'd1; v.rs2[0] = 5'd5; v.eq2[0] = 4'd3; v.ecnt = 6'd3; vecs.push_back(v);
        // V3 commit with matching tag
        v = '{default: '0}; v.cen = 2'b01; v.crd[0] = 5'd5; v.cq[0] = 4'd3; v.cv[0] = 32'hAB;
        v.rs1[0] = 5'd9; v.eq1[0] = 4'd2; v.ecnt = 6'd2; vecs.push_back(v);
        // V4 stale commit, dispatch to r0 ignored
        v = '{default: '0}; v.rs1[0] = 5'd5; v.ev1[0] = 32'hAB;
        v.cen = 2'b01; v.crd[0] = 5'd9; v.cq[0] = 4'd1; v.cv[0] = 32'd1;
        v.den = 2'b01; v.rd[0] = 5'd0; v.dq[0] = 4'd5; v.ecnt = 6'd2; vecs.push_back(v);
        // V5 allocation and matching commit collide; commit to r0 ignored
        v = '{default: '0}; v.rs1[0] = 5'd9; v.eq1[0] = 4'd2; v.ev1[0] = 32'd1;
        v.den = 2'b01; v.rd[0] = 5'd7; v.dq[0] = 4'd9;
        v.cen = 2'b11; v.crd[0] = 5'd7; v.cq[0] = 4'd4; v.cv[0] = 32'h55; v.crd[1] = 5'd0; v.cv[1] = 32'hFF;
        v.ecnt = 6'd2; vecs.push_back(v);
        // V6 commit ports collide, youngest value wins; two more allocations
        v = '{default: '0}; v.rs1[0] = 5'd7; v.eq1[0] = 4'd9; v.ev1[0] = 32'h55;
        v.cen = 2'b11; v.crd[0] = 5'd3; v.cv[0] = 32'h11; v.crd[1] = 5'd3; v.cv[1] = 32'h22;
        v.den = 2'b11; v.rd[0] = 5'd4; v.dq[0] = 4'd6; v.rd[1] = 5'd6; v.dq[1] = 4'd7;
        v.ecnt = 6'd4; vecs.push_back(v);
        // V7 rollback with dispatch and commit
        v = '{default: '0}; v.rb = 1'b1;
        v.rs1[0] = 5'd3; v.ev1[0] = 32'h22; v.rs1[1] = 5'd9; v.ev1[1] = 32'd1;
        v.rs2[0] = 5'd6; v.rs2[1] = 5'd6; v.eq2[1] = 4'd8;
        v.den = 2'b01; v.rd[0] = 5'd6; v.dq[0] = 4'd8;
        v.cen = 2'b01; v.crd[0] = 5'd4; v.cv[0] = 32'd2; v.ecnt = 6'd0; vecs.push_back(v);
        // V8 after rollback
        v = '{default: '0}; v.rs1[0] = 5'd4; v.ev1[0] = 32'd2; v.rs1[1] = 5'd6;
        v.rs2[0] = 5'd7; v.ev2[0] = 32'h55; v.rs2[1] = 5'd3; v.ev2[1] = 32'h22;
        v.ecnt = 6'd0; vecs.push_back(v);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_cnt", -1, 64'(pending_cnt), 64'd0);
        disp_rs1 = {5'd0, 5'd7};
        #1;
        chk("reset_q1", -1, 64'(rd_q1), 64'd0);
        chk("reset_v1", -1, rd_v1, 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #1;
            chk("q1", i, 64'(rd_q1), 64'(vecs[i].eq1));
            chk("q2", i, 64'(rd_q2), 64'(vecs[i].eq2));
            chk("v1", i, rd_v1, 64'(vecs[i].ev1));
            chk("v2", i, rd_v2, 64'(vecs[i].ev2));
            @(posedge clk);
            #1;
            idle();
            chk("cnt", i, 64'(pending_cnt), 64'(vecs[i].ecnt));
        end

        // Reset mid-stream overrides dispatch and commit
        disp_en = 2'b01; disp_rd = {5'd0, 5'd5}; disp_q = {4'd0, 4'd3};
        cmt_en = 2'b01; cmt_rd = {5'd0, 5'd3}; cmt_v = {32'd0, 32'h77};
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        disp_rs1 = {5'd7, 5'd3}; disp_rs2 = {5'd9, 5'd4};
        #1;
        chk("rst_cnt", -2, 64'(pending_cnt), 64'd0);
        chk("rst_q1", -2, 64'(rd_q1), 64'd0);
        chk("rst_q2", -2, 64'(rd_q2), 64'd0);
        chk("rst_v1", -2, rd_v1, 64'd0);
        chk("rst_v2", -2, rd_v2, 64'd0);

        // Same-cycle commit read of a renamed register
        disp_en = 2'b01; disp_rd = {5'd0, 5'd5}; disp_q = {4'd0, 4'd3};
        @(posedge clk);
        #1 idle();
        chk("byp_cnt_a", -3, 64'(pending_cnt), 64'd1);
        cmt_en = 2'b01; cmt_rd = {5'd0, 5'd5}; cmt_q = {4'd0, 4'd3}; cmt_v = {32'd0, 32'hAB};
        disp_rs1 = {5'd0, 5'd5};
        #1;
`ifdef RENAME_RF_CMT_BYPASS_EN
        chk("byp_q", -3, 64'(rd_q1), 64'd0);
        chk("byp_v", -3, rd_v1, 64'h0000_0000_0000_00AB);
`else
        chk("byp_q", -3, 64'(rd_q1), 64'd3);
        chk("byp_v", -3, rd_v1, 64'd0);
`endif
        @(posedge clk);
        #1 idle();
        disp_rs1 = {5'd0, 5'd5};
        #1;
        chk("post_q", -3, 64'(rd_q1), 64'd0);
        chk("post_v", -3, rd_v1, 64'h0000_0000_0000_00AB);
        chk("post_cnt", -3, 64'(pending_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
